// File: rtl/bombe_sweep_ctrl.sv
// Sweep sequencer for one bombe datapath: walks all 26^3 rotor triples from a
// host-supplied start, issues one attempt per triple and queues flagged hits.
module bombe_sweep_ctrl #(
  parameter int unsigned HIT_DEPTH = 8,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  start_pos_0,
  input  logic [4:0]  start_pos_1,
  input  logic [4:0]  start_pos_2,
  output logic [4:0]  bombe_pos_0,
  output logic [4:0]  bombe_pos_1,
  output logic [4:0]  bombe_pos_2,
  output logic        bombe_next_attempt,
  input  logic        bombe_finish,
  input  logic        bombe_valid,
  output logic        hit_valid,
  output logic [14:0] hit_data,
  input  logic        hit_pop,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [14:0] attempt_count
);

  localparam int unsigned AW = (HIT_DEPTH > 1) ? $clog2(HIT_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [14:0] SWEEP_LEN = 15'd17576;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_STALL,
    S_ADVANCE,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  pos0_q, pos0_d;
  logic [4:0]  pos1_q, pos1_d;
  logic [4:0]  pos2_q, pos2_d;
  logic [14:0] attempt_q, attempt_d;
  logic [9:0]  wdog_q, wdog_d;
  logic [9:0]  wdog_inc;
  logic        terr_q, terr_d;

  logic [14:0]   mem_q [HIT_DEPTH];
  logic [14:0]   mem_d [HIT_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_next;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [14:0]   head_q, head_d;

  logic        push;
  logic        pop;
  logic        fifo_clear;
  logic        fifo_full;
  logic [14:0] push_data;

  function automatic logic [4:0] wrap26(input logic [4:0] v);
    return (v >= 5'd26) ? v - 5'd26 : v;
  endfunction

  assign fifo_full = (cnt_q == CW'(HIT_DEPTH));
  assign push_data = {pos2_q, pos1_q, pos0_q};
  assign wdog_inc  = wdog_q + 10'd1;

  always_comb begin
    state_d    = state_q;
    pos0_d     = pos0_q;
    pos1_d     = pos1_q;
    pos2_d     = pos2_q;
    attempt_d  = attempt_q;
    wdog_d     = wdog_q;
    terr_d     = terr_q;
    push       = 1'b0;
    fifo_clear = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            pos0_d     = wrap26(start_pos_0);
            pos1_d     = wrap26(start_pos_1);
            pos2_d     = wrap26(start_pos_2);
            attempt_d  = '0;
            terr_d     = 1'b0;
            fifo_clear = 1'b1;
            state_d    = S_ISSUE;
          end
        end
        S_ISSUE: begin
          wdog_d  = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          wdog_d = wdog_inc;
          if (bombe_finish) begin
            // A full FIFO only blocks the hit if the host is not popping this cycle.
            if (bombe_valid && fifo_full && !hit_pop) begin
              state_d = S_STALL;
            end else begin
              push      = bombe_valid;
              attempt_d = attempt_q + 15'd1;
              state_d   = S_ADVANCE;
            end
          end else if (wdog_inc == 10'(TIMEOUT)) begin
            terr_d  = 1'b1;
            state_d = S_DONE;
          end
        end
        S_STALL: begin
          if (!fifo_full || hit_pop) begin
            push      = 1'b1;
            attempt_d = attempt_q + 15'd1;
            state_d   = S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          if (attempt_q == SWEEP_LEN) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            if (pos0_q == 5'd25) begin
              pos0_d = '0;
              if (pos1_q == 5'd25) begin
                pos1_d = '0;
                pos2_d = (pos2_q == 5'd25) ? 5'd0 : pos2_q + 5'd1;
              end else begin
                pos1_d = pos1_q + 5'd1;
              end
            end else begin
              pos0_d = pos0_q + 5'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Hit FIFO; head_q mirrors mem_q[rd_ptr_q] so hit_data comes straight off a flop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    head_d   = head_q;
    rd_next  = rd_ptr_q + AW'(1);
    pop      = hit_pop && (cnt_q != '0) && !fifo_clear;

    if (fifo_clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      head_d   = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_next;
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      if (pop) begin
        if (cnt_q >= CW'(2)) begin
          head_d = mem_q[rd_next];
        end else if (push) begin
          head_d = push_data;
        end
      end else if (push && (cnt_q == '0)) begin
        head_d = push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pos0_q    <= '0;
      pos1_q    <= '0;
      pos2_q    <= '0;
      attempt_q <= '0;
      wdog_q    <= '0;
      terr_q    <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      head_q    <= '0;
    end else begin
      state_q   <= state_d;
      pos0_q    <= pos0_d;
      pos1_q    <= pos1_d;
      pos2_q    <= pos2_d;
      attempt_q <= attempt_d;
      wdog_q    <= wdog_d;
      terr_q    <= terr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      head_q    <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < HIT_DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign bombe_pos_0        = pos0_q;
  assign bombe_pos_1        = pos1_q;
  assign bombe_pos_2        = pos2_q;
  assign bombe_next_attempt = (state_q == S_ISSUE);
  assign hit_valid          = (cnt_q != '0);
  assign hit_data           = head_q;
  assign busy               = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                              (state_q == S_STALL) || (state_q == S_ADVANCE);
  assign done               = (state_q == S_DONE);
  assign timeout_err        = terr_q;
  assign attempt_count      = attempt_q;

endmodule

// File: tb/tb_bombe_sweep_ctrl.sv
// Bench for bombe_sweep_ctrl: a behavioural bombe model predicts every issued
// triple and every hit from linear sweep arithmetic; a monitor checks the FIFO.
module tb_bombe_sweep_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 1023;
  localparam int unsigned NPOS  = 17576;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [4:0]  start_pos_0, start_pos_1, start_pos_2;
  logic [4:0]  bombe_pos_0, bombe_pos_1, bombe_pos_2;
  logic        bombe_next_attempt;
  logic        bombe_finish, bombe_valid;
  logic        hit_valid;
  logic [14:0] hit_data;
  logic        hit_pop;
  logic        busy, done, timeout_err;
  logic [14:0] attempt_count;

  bombe_sweep_ctrl #(.HIT_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .start_pos_0(start_pos_0), .start_pos_1(start_pos_1), .start_pos_2(start_pos_2),
    .bombe_pos_0(bombe_pos_0), .bombe_pos_1(bombe_pos_1), .bombe_pos_2(bombe_pos_2),
    .bombe_next_attempt(bombe_next_attempt), .bombe_finish(bombe_finish),
    .bombe_valid(bombe_valid), .hit_valid(hit_valid), .hit_data(hit_data),
    .hit_pop(hit_pop), .busy(busy), .done(done), .timeout_err(timeout_err),
    .attempt_count(attempt_count)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int unsigned red26(input int unsigned v);
    return (v >= 26) ? v - 26 : v;
  endfunction

  // Linear sweep index -> packed {pos_2,pos_1,pos_0}
  function automatic int pack_lin(input int unsigned lin);
    return int'(((lin / 676) << 10) | (((lin / 26) % 26) << 5) | (lin % 26));
  endfunction

  // Stimulus-owned controls read by the model
  int unsigned base = 0;
  int unsigned gen = 0, agen = 0;
  int unsigned policy = 0;
  int unsigned fin_delay = 1;
  bit          nofinish = 1'b0;
  bit          pop_rand = 1'b0;

  // Model-owned state
  int unsigned issue_idx = 0;
  int unsigned last_issue_cyc = 0;
  int unsigned seen_gen = 0, seen_agen = 0;
  int unsigned hits3 = 0;
  bit          pend = 1'b0;
  int unsigned pend_cnt = 0;
  int unsigned pend_lin = 0;
  logic [14:0] hit_q[$];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bombe model (drives at negedge) and hit monitor (negedge + 2)
  always begin
    @(negedge clk);
    bombe_finish = 1'b0;
    bombe_valid  = 1'($urandom_range(0, 1));
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bit v;
        pend = 1'b0;
        case (policy)
          1: v = ((pend_lin % 26) == 3) && (hits3 < 3);
          2: v = 1'b1;
          3: v = ($urandom_range(0, 3) == 0);
          default: v = 1'b0;
        endcase
        if (v && policy == 1) hits3++;
        bombe_finish = 1'b1;
        bombe_valid  = v;
        if (v) hit_q.push_back(15'(pack_lin(pend_lin)));
      end
    end
    if (bombe_next_attempt) begin
      int unsigned lin;
      lin = (base + issue_idx) % NPOS;
      check("issue_pos", int'({bombe_pos_2, bombe_pos_1, bombe_pos_0}), pack_lin(lin));
      issue_idx++;
      last_issue_cyc = cyc;
      if (!nofinish) begin
        pend     = 1'b1;
        pend_lin = lin;
        pend_cnt = (fin_delay != 0) ? fin_delay : $urandom_range(1, 4);
      end
    end

    #2;
    if (gen != seen_gen) begin
      seen_gen  = gen;
      issue_idx = 0;
      hits3     = 0;
      pend      = 1'b0;
      hit_q.delete();
    end
    if (agen != seen_agen) begin
      seen_agen = agen;
      pend      = 1'b0;
    end
    if (hit_valid && hit_pop) begin
      if (hit_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL hit_extra: got 0x%0h expected no entry", hit_data);
      end else begin
        logic [14:0] e;
        e = hit_q.pop_front();
        check("hit_data", int'(hit_data), int'(e));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    hit_pop = pop_rand ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic run(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic do_start(input int unsigned a, input int unsigned b, input int unsigned c);
    start_pos_0 = 5'(a);
    start_pos_1 = 5'(b);
    start_pos_2 = 5'(c);
    start   = 1'b1;
    hit_pop = 1'b0;
    base    = red26(a) + 26 * red26(b) + 676 * red26(c);
    gen++;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort(input bit with_start);
    abort = 1'b1;
    start = with_start;
    start_pos_0 = 5'd7;
    start_pos_1 = 5'd7;
    start_pos_2 = 5'd7;
    agen++;
    tick();
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_issues(input int unsigned n, input int unsigned bound, input string name);
    int unsigned k = 0;
    while (issue_idx < n && k < bound) begin
      tick();
      k++;
    end
    check(name, int'(issue_idx >= n), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pos"}, int'({bombe_pos_2, bombe_pos_1, bombe_pos_0}), 0);
    check({tag, "_next_attempt"}, int'(bombe_next_attempt), 0);
    check({tag, "_hit_valid"}, int'(hit_valid), 0);
    check({tag, "_hit_data"}, int'(hit_data), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_timeout_err"}, int'(timeout_err), 0);
    check({tag, "_attempt_count"}, int'(attempt_count), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; hit_pop = 1'b0;
    start_pos_0 = '0; start_pos_1 = '0; start_pos_2 = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_all_zero("reset");

    // Full sweep, never valid
    policy = 0; fin_delay = 1; pop_rand = 0;
    do_start(21, 4, 16);
    check("sweep_busy", int'(busy), 1);
    begin
      int unsigned k = 0;
      while (!done && k < 60000) begin
        tick();
        k++;
      end
    end
    check("sweep_done", int'(done), 1);
    check("sweep_busy_end", int'(busy), 0);
    check("sweep_attempts", int'(attempt_count), int'(NPOS));
    check("sweep_issues", int'(issue_idx), int'(NPOS));
    check("sweep_last_pos", int'({bombe_pos_2, bombe_pos_1, bombe_pos_0}),
          pack_lin((base + NPOS - 1) % NPOS));
    check("sweep_no_timeout", int'(timeout_err), 0);

    // Hits at pos_0 == 3, then abort+start mid-WAIT, then restart
    policy = 1; fin_delay = 1; pop_rand = 0;
    do_start(0, 4, 16);
    run(250);
    check("hits_present", int'(hit_valid), 1);
    pop_rand = 1;
    run(30);
    pop_rand = 0;
    tick();
    check("hits_drained", int'(hit_valid), 0);
    check("hits_all_seen", int'(hit_q.size()), 0);
    fin_delay = 8;
    begin
      int unsigned n;
      n = issue_idx;
      wait_issues(n + 1, 20, "abort_issue_seen");
      tick();
      do_abort(1'b1);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_attempts_kept", int'(attempt_count), int'(issue_idx) - 1);
      n = issue_idx;
      run(20);
      check("abort_no_issue", int'(issue_idx), int'(n));
    end
    fin_delay = 1; policy = 0;
    do_start(30, 2, 27);
    check("restart_attempts", int'(attempt_count), 0);
    wait_issues(1, 10, "restart_issue");
    run(20);
    do_abort(1'b0);

    // Stall with every attempt valid and no pops
    policy = 2; fin_delay = 1; pop_rand = 0;
    do_start($urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25));
    wait_issues(DEPTH + 1, 60, "stall_reach");
    run(40);
    check("stall_issues", int'(issue_idx), int'(DEPTH + 1));
    check("stall_busy", int'(busy), 1);
    check("stall_attempts", int'(attempt_count), int'(DEPTH));
    check("stall_hit_valid", int'(hit_valid), 1);
    hit_pop = 1'b1;
    tick();
    wait_issues(DEPTH + 2, 10, "stall_release");
    pop_rand = 1;
    run(150);
    policy = 0;
    run(80);
    do_abort(1'b0);
    run(20);
    check("stall_fifo_empty", int'(hit_valid), 0);
    check("stall_all_seen", int'(hit_q.size()), 0);

    // Random delays/valids/pops with an ignored start mid-sweep
    policy = 3; fin_delay = 0; pop_rand = 1;
    do_start($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
    run(300);
    start_pos_0 = 5'($urandom_range(0, 25));
    start_pos_1 = 5'($urandom_range(0, 25));
    start_pos_2 = 5'($urandom_range(0, 25));
    start = 1'b1;
    tick();
    start = 1'b0;
    run(300);
    policy = 0;
    run(60);
    do_abort(1'b0);
    run(20);
    check("rand_fifo_empty", int'(hit_valid), 0);
    check("rand_all_seen", int'(hit_q.size()), 0);

    // Watchdog timeout
    nofinish = 1; policy = 0; pop_rand = 0;
    do_start($urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25));
    wait_issues(1, 10, "timeout_issue");
    begin
      int unsigned k = 0;
      while (cyc < last_issue_cyc + TMO && k < 2 * TMO) begin
        tick();
        k++;
      end
    end
    check("timeout_not_early", int'(done), 0);
    tick();
    check("timeout_done", int'(done), 1);
    check("timeout_err", int'(timeout_err), 1);
    run(20);
    check("timeout_single_issue", int'(issue_idx), 1);
    nofinish = 0;
    do_start(1, 2, 3);
    check("timeout_err_cleared", int'(timeout_err), 0);
    run(10);
    do_abort(1'b0);

    // Reset mid-sweep
    policy = 3; fin_delay = 0; pop_rand = 0;
    do_start($urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25));
    run(60);
    reset = 1'b1;
    gen++;
    tick();
    reset = 1'b0;
    check_all_zero("midreset");
    run(5);
    check("midreset_idle", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bombe_sweep_ctrl.md
# bombe_sweep_ctrl

Sequencer that drives one `bombe` datapath through a full rotor-position sweep. Starting from a host-supplied rotor triple, it steps through all 26^3 = 17576 positions and issues one attempt per position. It waits for the bombe to finish each attempt and pushes every position the bombe flags valid into a small hit FIFO, which the host drains. It sits between the host/HPS register interface and the `bombe` instance, and owns `init_rotor_position_*`, `next_attempt_1`, and the `finish_compute`/`valid_output` consumption.

## Interface
- `HIT_DEPTH`, default 8: hit FIFO entries, power of 2, ≥ 2.
- `TIMEOUT`, default 1023: max cycles allowed from attempt issue to `bombe_finish`; 10-bit counter.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; accepted only in IDLE or DONE.
- `abort` in 1: return to IDLE from any state.
- `start_pos_0/1/2` in 5 each: first rotor triple, values 0–25; sampled on accepted `start`.
- `bombe_pos_0/1/2` out 5 each: drive `init_rotor_position_0/1/2`.
- `bombe_next_attempt` out 1: drives `next_attempt_1`; one-cycle pulse per attempt.
- `bombe_finish` in 1: from `finish_compute`.
- `bombe_valid` in 1: from `valid_output`; sampled only when `bombe_finish` is 1.
- `hit_valid` out 1: FIFO non-empty.
- `hit_data` out 15: `{pos_2,pos_1,pos_0}` of the oldest hit.
- `hit_pop` in 1: consume the head entry when `hit_valid` is 1; ignored when the FIFO is empty.
- `busy` out 1: state is not IDLE or DONE.
- `done` out 1: state is DONE.
- `timeout_err` out 1: sticky; cleared by accepted `start` or by `reset`.
- `attempt_count` out 15: attempts completed in the current sweep.

## Operation
- States: IDLE, ISSUE, WAIT, STALL, ADVANCE, DONE.
- IDLE/DONE + `start`: latch `start_pos_*` into `bombe_pos_*`; clear `attempt_count`, `timeout_err`, and the FIFO; go to ISSUE.
- ISSUE: assert `bombe_next_attempt` for exactly this cycle; clear the watchdog; go to WAIT.
- WAIT: the watchdog increments each cycle. On `bombe_finish`:
  - If `bombe_valid` and the FIFO is full with no simultaneous pop, go to STALL.
  - Else, if `bombe_valid`, push the current positions.
  - Increment `attempt_count` in both non-stall cases and go to ADVANCE.
- WAIT timeout: when the watchdog reaches `TIMEOUT` with no `bombe_finish`, set `timeout_err` and go to DONE.
- STALL: the pending hit is held. The first cycle the FIFO is not full, or `hit_pop` frees an entry in the same cycle, push the hit, increment `attempt_count`, and go to ADVANCE.
- ADVANCE:
  - If `attempt_count == 17576`, go to DONE; positions stay at the last triple.
  - Otherwise, odometer-step the rotor positions: `pos_0` is the fastest. 25 wraps to 0 and carries into `pos_1`, which carries into `pos_2`; `pos_2` wraps 25→0 with no carry. Then go to ISSUE.
- Sweep length: one sweep always covers 17576 attempts and ends at the triple just before the start triple, modulo the odometer.
- `abort`: forces IDLE next cycle and has priority over every other input. The FIFO contents and `attempt_count` are kept; `bombe_next_attempt` is low on the following cycle.
- `start` in a busy state (ISSUE/WAIT/STALL/ADVANCE): ignored.
- `start` and `abort` in the same cycle: `abort` wins.
- FIFO:
  - Simultaneous push and pop when full: both take effect, and the count stays at `HIT_DEPTH`.
  - Pop when empty: ignored.
  - `hit_data` is the registered head entry, valid whenever `hit_valid` is 1.
- Values ≥ 26 on `start_pos_*`: reduced by 26 when latched.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, `bombe_pos_*` = 0.
- `start` accepted at edge N: `bombe_pos_*` is valid after edge N, and `bombe_next_attempt` is high during cycle N+1.
- `bombe_finish` seen at edge M with no stall: ADVANCE is cycle M+1, and the next `bombe_next_attempt` is high in cycle M+2. Overhead is 3 cycles per attempt beyond bombe compute time.
- Hit push at edge M: `hit_valid` is high from cycle M+1.
- `done` rises the cycle after ADVANCE detects 17576 attempts.
- `bombe_finish` outside WAIT: ignored.

## Test plan
- Start at (V=21, E=4, Q=16) with a bombe model finishing 5 cycles after each issue and never valid → exactly 17576 `bombe_next_attempt` pulses. Positions step (21,4,16)→(22,4,16)…(25,4,16)→(0,5,16); the last issued triple is (20,4,16); `done` = 1, `attempt_count` = 17576.
- Model flags valid at pos_0 = 3 for the first 3 such attempts → 3 FIFO entries: `hit_data` = {16,4,3}, {16,5,3}, {16,6,3}, in order as popped.
- `HIT_DEPTH` = 2, no pops, 3 valid results → the controller holds in STALL with no further `bombe_next_attempt`. Popping once releases it; the third hit is then pushed and the sweep resumes.
- Model never asserts `bombe_finish` → `timeout_err` = 1 and `done` = 1 `TIMEOUT` cycles after the first issue, with no second pulse.
- `abort` asserted mid-WAIT, together with a `start` pulse in the same cycle → IDLE next cycle, `busy` = 0, no new issue. A later `start` restarts from the new `start_pos_*` with `attempt_count` = 0.
- `reset` asserted mid-sweep for one cycle → all outputs 0 and FIFO empty on the next cycle.
